multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

- Multi-cycle control FSM for the RV32I core.
- Sequences instruction fetch, decode, the execute stage (ALU plus branch-target adder), data memory access and register writeback.
- Drives the execute stage's ALU operand select and 4-bit ALU control, and resolves branches from the ALU zero flag.
- Handshakes with instruction and data memories that may stall for any number of cycles.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  instr[6:0] from the datapath instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag from the execute stage
- imem_ready  in  1  instruction memory has data this cycle
- dmem_ready  in  1  data memory has completed the access this cycle
- imem_req  out  1  instruction fetch request
- irWrite  out  1  load IR and capture the instruction PC (drives the execute-stage pcOut)
- pcWrite  out  1  update the PC register
- pcSrc  out  1  0 = PC+4, 1 = branch target (execute-stage adder output)
- aluSel  out  1  ALU operand-2 select: 0 = data2, 1 = imm
- aluCtrl  out  4  ALU operation code
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable (store)
- regWrite  out  1  register file write enable
- memToReg  out  1  writeback source: 0 = aluRes, 1 = load data
- illegal  out  1  illegal instruction halt flag (see Configuration)

## Operation
States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT.

Transitions:
- IDLE -> FETCH unconditionally.
- FETCH holds while imem_ready=0 and moves to DECODE on imem_ready=1.
- DECODE -> EXECUTE.
- EXECUTE:
  - R-type and I-ALU -> WB.
  - LOAD and STORE -> MEM.
  - BRANCH -> FETCH.
- MEM holds while dmem_ready=0. On dmem_ready=1, LOAD -> WB and STORE -> FETCH.
- WB -> FETCH.

Decode:
- DECODE latches the instruction class (R, IALU, LOAD, STORE, BRANCH, ILL) plus funct3 and funct7b5 into registers.
- Supported opcodes: 0110011, 0010011, 0000011, 0100011, 1100011. Any other opcode is ILL.
- A BRANCH with funct3 010 or 011 is ILL.

Outputs are combinational from the state and the latched class only. zero is used in EXECUTE only.

Output behaviour by state:
- FETCH: imem_req=1. On the imem_ready cycle, irWrite=1, pcWrite=1 and pcSrc=0.
- EXECUTE, aluSel: 1 for IALU, LOAD and STORE; 0 for R and BRANCH.
- aluCtrl encoding: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000, SLTU 1001.
- R-type and IALU: aluCtrl from funct3. funct7b5 selects SUB or SRA. For IALU, funct7b5 is honoured only for the shift funct3 (101).
- LOAD and STORE: aluCtrl = ADD.
- Branch ALU op and taken condition:
  - BEQ: SUB, taken when zero.
  - BNE: SUB, taken when !zero.
  - BLT: SLT, taken when !zero.
  - BGE: SLT, taken when zero.
  - BLTU: SLTU, taken when !zero.
  - BGEU: SLTU, taken when zero.
- A taken branch asserts pcWrite=1 and pcSrc=1 in EXECUTE.
- MEM: dmem_req=1, and dmem_we=1 for STORE. Both are held until and including the dmem_ready cycle.
- WB: regWrite=1 for exactly one cycle. memToReg=1 for LOAD.
- All other outputs are 0 unless stated. aluCtrl = ADD outside EXECUTE.

## Timing
- Reset:
  - rst_n low forces IDLE immediately, from any state, including mid-handshake. Any outstanding memory request is abandoned.
  - In IDLE all outputs are 0, aluCtrl=0010, illegal=0.
  - The first imem_req is asserted one cycle after rst_n is released.
- Minimum latency, in cycles from FETCH entry with zero-wait memories:
  - BRANCH: 3.
  - R/IALU: 4.
  - STORE: 4.
  - LOAD: 5.
- Each memory wait cycle adds one cycle.
- The req signals never drop before ready is sampled high. A ready arriving while not in FETCH or MEM is ignored.

## Configuration
- CTRL_ILLEGAL_HALT_EN defined:
  - An ILL class in DECODE transitions to HALT.
  - HALT drives all outputs 0 except illegal=1, which is sticky.
  - HALT exits only on reset.
- CTRL_ILLEGAL_HALT_EN undefined:
  - ILL is treated as a NOP: DECODE -> FETCH with no writes.
  - illegal is tied to 0 and HALT is not generated.

## Structure
- Shared package rv_ctrl_pkg holds:
  - the aluCtrl codes;
  - the RV32I opcode constants;
  - the instruction-class encodings;
  - the state encodings.
- One sub-module, alu_decoder, maps (class, funct3, funct7b5) to aluCtrl, aluSel and the branch-invert bit. It is purely combinational.

## Test plan
- **Reset release.** Release reset with imem_ready=1. Required: IDLE for one cycle, then imem_req=1, irWrite=1, pcWrite=1 in the same cycle.
- **R-type SUB.** opcode 0110011, funct3 000, funct7b5 1. Required: aluCtrl=0110 and aluSel=0 in EXECUTE; regWrite=1 in the following cycle; 4 cycles total.
- **LOAD with memory stall.** opcode 0000011, dmem_ready low for 3 cycles. Required: dmem_req=1 and dmem_we=0 held for 4 cycles; then regWrite=1 and memToReg=1 for one cycle; 8 cycles total.
- **Branch resolution.**
  - BNE with zero=0: pcWrite=1 and pcSrc=1 in EXECUTE.
  - BGE with zero=0: no pcWrite in EXECUTE; next state is FETCH.
- **Reset mid-operation.** Assert rst_n low during the MEM stall of a STORE. Required: dmem_req drops immediately and the FSM restarts from IDLE.
- **Illegal opcode 1111111.**
  - With CTRL_ILLEGAL_HALT_EN: illegal=1 and no further imem_req until reset.
  - Without CTRL_ILLEGAL_HALT_EN: next FETCH occurs and regWrite is never asserted.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: ALU operation
// codes, base opcodes, instruction classes and controller states.
package rv_ctrl_pkg;

  // Execute-stage ALU operation codes
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  // RV32I base opcodes handled by this core
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Instruction class latched in DECODE
  typedef enum logic [2:0] {
    CLS_R,
    CLS_IALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ILL
  } instr_class_e;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  // Map opcode (and funct3 for branches) to an instruction class
  function automatic instr_class_e classify(input logic [6:0] opcode,
                                            input logic [2:0] funct3);
    instr_class_e cls;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_IALU:   cls = CLS_IALU;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      // funct3 010/011 have no branch encoding
      OP_BRANCH: cls = (funct3 == 3'b010 || funct3 == 3'b011) ? CLS_ILL : CLS_BRANCH;
      default:   cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: (class, funct3, funct7b5) -> ALU op, operand-2
// select and branch-invert bit (taken = zero ^ br_inv).
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  instr_class_e cls_i,
  input  logic [2:0]   funct3_i,
  input  logic         funct7b5_i,
  output alu_op_e      alu_ctrl_o,
  output logic         alu_sel_o,
  output logic         br_inv_o
);

  // Decode ALU controls for the latched instruction
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    alu_sel_o  = 1'b0;
    br_inv_o   = 1'b0;
    case (cls_i)
      CLS_R, CLS_IALU: begin
        alu_sel_o = (cls_i == CLS_IALU);
        case (funct3_i)
          // ADDI has no subtract form, so funct7b5 only matters for R-type here
          3'b000:  alu_ctrl_o = (cls_i == CLS_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  alu_ctrl_o = ALU_SLTU;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      CLS_LOAD, CLS_STORE: begin
        alu_sel_o  = 1'b1;
        alu_ctrl_o = ALU_ADD;
      end
      CLS_BRANCH: begin
        case (funct3_i)
          3'b000: begin alu_ctrl_o = ALU_SUB;  br_inv_o = 1'b0; end // BEQ
          3'b001: begin alu_ctrl_o = ALU_SUB;  br_inv_o = 1'b1; end // BNE
          3'b100: begin alu_ctrl_o = ALU_SLT;  br_inv_o = 1'b1; end // BLT
          3'b101: begin alu_ctrl_o = ALU_SLT;  br_inv_o = 1'b0; end // BGE
          3'b110: begin alu_ctrl_o = ALU_SLTU; br_inv_o = 1'b1; end // BLTU
          3'b111: begin alu_ctrl_o = ALU_SLTU; br_inv_o = 1'b0; end // BGEU
          default: begin alu_ctrl_o = ALU_SUB; br_inv_o = 1'b0; end
        endcase
      end
      default: begin
        alu_ctrl_o = ALU_ADD;
        alu_sel_o  = 1'b0;
        br_inv_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch, decode, execute,
// memory and writeback with stallable instruction/data memory handshakes.
// Optional feature macro: CTRL_ILLEGAL_HALT_EN (illegal instruction -> HALT).
module multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       pcSrc,
  output logic       aluSel,
  output logic [3:0] aluCtrl,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       regWrite,
  output logic       memToReg,
  output logic       illegal
);

  state_e       state_q, state_d;
  instr_class_e cls_q, cls_d;
  logic [2:0]   funct3_q, funct3_d;
  logic         funct7b5_q, funct7b5_d;

  instr_class_e dec_cls;
  alu_op_e      dec_alu_ctrl;
  logic         dec_alu_sel;
  logic         dec_br_inv;

  assign dec_cls = classify(opcode, funct3);

  alu_decoder u_alu_decoder (
    .cls_i      (cls_q),
    .funct3_i   (funct3_q),
    .funct7b5_i (funct7b5_q),
    .alu_ctrl_o (dec_alu_ctrl),
    .alu_sel_o  (dec_alu_sel),
    .br_inv_o   (dec_br_inv)
  );

  // Next state and DECODE-time capture of class / function fields
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    funct3_d   = funct3_q;
    funct7b5_d = funct7b5_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
      S_DECODE: begin
        cls_d      = dec_cls;
        funct3_d   = funct3;
        funct7b5_d = funct7b5;
        if (dec_cls == CLS_ILL) begin
`ifdef CTRL_ILLEGAL_HALT_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (cls_q)
          CLS_R, CLS_IALU:     state_d = S_WB;
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          default:             state_d = S_FETCH;
        endcase
      end
      S_MEM: if (dmem_ready) state_d = (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
      S_WB:  state_d = S_FETCH;
      S_HALT: begin
`ifdef CTRL_ILLEGAL_HALT_EN
        state_d = S_HALT;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched decode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cls_q      <= CLS_R;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
    end
  end

  // Control outputs from state and latched class; ready/zero gate single cycles
  always_comb begin
    imem_req = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    pcSrc    = 1'b0;
    aluSel   = 1'b0;
    aluCtrl  = ALU_ADD;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    regWrite = 1'b0;
    memToReg = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          pcSrc   = 1'b0;
        end
      end
      S_EXECUTE: begin
        aluSel  = dec_alu_sel;
        aluCtrl = dec_alu_ctrl;
        if (cls_q == CLS_BRANCH && (zero ^ dec_br_inv)) begin
          pcWrite = 1'b1;
          pcSrc   = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
      end
      S_WB: begin
        regWrite = 1'b1;
        memToReg = (cls_q == CLS_LOAD);
      end
      S_HALT: begin
`ifdef CTRL_ILLEGAL_HALT_EN
        illegal = 1'b1;
        aluCtrl = '0;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req, irWrite, pcWrite, pcSrc, aluSel;
  logic [3:0] aluCtrl;
  logic       dmem_req, dmem_we, regWrite, memToReg, illegal;

  int unsigned vectors = 0;
  int unsigned fails   = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .irWrite    (irWrite),
    .pcWrite    (pcWrite),
    .pcSrc      (pcSrc),
    .aluSel     (aluSel),
    .aluCtrl    (aluCtrl),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .regWrite   (regWrite),
    .memToReg   (memToReg),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // {imem_req, irWrite, pcWrite, pcSrc, aluSel, aluCtrl, dmem_req, dmem_we, regWrite, memToReg, illegal}
  logic [13:0] obs;
  assign obs = {imem_req, irWrite, pcWrite, pcSrc, aluSel, aluCtrl,
                dmem_req, dmem_we, regWrite, memToReg, illegal};

  function automatic logic [13:0] ex(input logic ireq, input logic irw, input logic pcw,
                                     input logic pcs, input logic asel, input logic [3:0] actl,
                                     input logic dreq, input logic dwe, input logic rw,
                                     input logic m2r, input logic ill);
    return {ireq, irw, pcw, pcs, asel, actl, dreq, dwe, rw, m2r, ill};
  endfunction

  localparam logic [13:0] O_IDLE   = 14'b0_0_0_0_0_0010_0_0_0_0_0;
  localparam logic [13:0] O_FSTALL = 14'b1_0_0_0_0_0010_0_0_0_0_0;
  localparam logic [13:0] O_FETCH  = 14'b1_1_1_0_0_0010_0_0_0_0_0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [13:0] exp_v);
    #1;
    vectors++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%b required=%b", tag, obs, exp_v);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0;
    zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #12;
    chk("reset_idle", O_IDLE);

    // Reset release with imem_ready already high
    imem_ready = 1'b1;
    rst_n = 1'b1;
    chk("idle_after_release", O_IDLE);
    opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;   // SUB
    tick(); chk("first_fetch", O_FETCH);

    // R-type SUB: F D E WB
    tick(); imem_ready = 1'b0; dmem_ready = 1'b1;             // stray ready ignored
    chk("sub_decode", O_IDLE);
    tick(); dmem_ready = 1'b0; chk("sub_execute", ex(0,0,0,0,0,4'b0110,0,0,0,0,0));
    tick(); chk("sub_wb", ex(0,0,0,0,0,4'b0010,0,0,1,0,0));
    tick(); chk("sub_next_fetch_stall", O_FSTALL);

    // LOAD with 3 dmem wait cycles
    opcode = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    tick(); chk("ld_fetch_stall2", O_FSTALL);
    imem_ready = 1'b1; chk("ld_fetch", O_FETCH);
    tick(); imem_ready = 1'b0; chk("ld_decode", O_IDLE);
    tick(); chk("ld_execute", ex(0,0,0,0,1,4'b0010,0,0,0,0,0));
    tick(); chk("ld_mem_w1", ex(0,0,0,0,0,4'b0010,1,0,0,0,0));
    tick(); chk("ld_mem_w2", ex(0,0,0,0,0,4'b0010,1,0,0,0,0));
    tick(); chk("ld_mem_w3", ex(0,0,0,0,0,4'b0010,1,0,0,0,0));
    tick(); dmem_ready = 1'b1; chk("ld_mem_ready", ex(0,0,0,0,0,4'b0010,1,0,0,0,0));
    tick(); dmem_ready = 1'b0; chk("ld_wb", ex(0,0,0,0,0,4'b0010,0,0,1,1,0));
    tick(); chk("ld_next_fetch", O_FSTALL);

    // BNE, zero=0 -> taken; zero=1 -> not taken
    opcode = 7'b1100011; funct3 = 3'b001; imem_ready = 1'b1;
    chk("bne_fetch", O_FETCH);
    tick(); imem_ready = 1'b0; chk("bne_decode", O_IDLE);
    tick(); zero = 1'b0; chk("bne_taken", ex(0,0,1,1,0,4'b0110,0,0,0,0,0));
    zero = 1'b1; chk("bne_not_taken", ex(0,0,0,0,0,4'b0110,0,0,0,0,0));
    tick(); zero = 1'b0; chk("bne_next_fetch", O_FSTALL);

    // BGE, zero=0 -> not taken, back to FETCH
    funct3 = 3'b101; imem_ready = 1'b1;
    chk("bge_fetch", O_FETCH);
    tick(); imem_ready = 1'b0; chk("bge_decode", O_IDLE);
    tick(); chk("bge_not_taken", ex(0,0,0,0,0,4'b0111,0,0,0,0,0));
    tick(); chk("bge_next_fetch", O_FSTALL);

    // BGEU, zero=1 -> taken with SLTU
    funct3 = 3'b111; imem_ready = 1'b1;
    tick(); imem_ready = 1'b0; chk("bgeu_decode", O_IDLE);
    tick(); zero = 1'b1; chk("bgeu_taken", ex(0,0,1,1,0,4'b1001,0,0,0,0,0));
    tick(); zero = 1'b0; chk("bgeu_next_fetch", O_FSTALL);

    // SRAI honours funct7b5
    opcode = 7'b0010011; funct3 = 3'b101; funct7b5 = 1'b1; imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    tick(); chk("srai_execute", ex(0,0,0,0,1,4'b1000,0,0,0,0,0));
    tick(); chk("srai_wb", ex(0,0,0,0,0,4'b0010,0,0,1,0,0));

    // ADDI ignores funct7b5
    funct3 = 3'b000; funct7b5 = 1'b1;
    tick(); imem_ready = 1'b1; chk("addi_fetch", O_FETCH);
    tick(); imem_ready = 1'b0;
    tick(); chk("addi_execute", ex(0,0,0,0,1,4'b0010,0,0,0,0,0));
    tick(); funct7b5 = 1'b0;

    // STORE, reset asserted during MEM stall
    opcode = 7'b0100011; funct3 = 3'b010;
    tick(); imem_ready = 1'b1; chk("st_fetch", O_FETCH);
    tick(); imem_ready = 1'b0;
    tick(); chk("st_execute", ex(0,0,0,0,1,4'b0010,0,0,0,0,0));
    tick(); chk("st_mem_w1", ex(0,0,0,0,0,4'b0010,1,1,0,0,0));
    tick(); chk("st_mem_w2", ex(0,0,0,0,0,4'b0010,1,1,0,0,0));
    rst_n = 1'b0; chk("st_reset_drop", O_IDLE);
    tick(); dmem_ready = 1'b1; chk("st_reset_hold", O_IDLE);
    dmem_ready = 1'b0; rst_n = 1'b1; chk("st_restart_idle", O_IDLE);
    tick(); chk("st_restart_fetch", O_FSTALL);

    // Illegal opcode
    opcode = 7'b1111111; funct3 = 3'b000; imem_ready = 1'b1;
    chk("ill_fetch", O_FETCH);
    tick(); imem_ready = 1'b0; chk("ill_decode", O_IDLE);
`ifdef CTRL_ILLEGAL_HALT_EN
    tick(); imem_ready = 1'b1; chk("ill_halt", ex(0,0,0,0,0,4'b0000,0,0,0,0,1));
    tick(); chk("ill_halt_sticky1", ex(0,0,0,0,0,4'b0000,0,0,0,0,1));
    tick(); chk("ill_halt_sticky2", ex(0,0,0,0,0,4'b0000,0,0,0,0,1));
    rst_n = 1'b0; chk("ill_halt_reset", O_IDLE);
    tick(); rst_n = 1'b1; imem_ready = 1'b0;
    tick(); chk("ill_after_reset_fetch", O_FSTALL);
`else
    tick(); chk("ill_nop_fetch", O_FSTALL);
    imem_ready = 1'b1; chk("ill_nop_fetch_ready", O_FETCH);
    tick(); imem_ready = 1'b0; chk("ill_nop_decode2", O_IDLE);
    tick(); chk("ill_nop_no_write", O_FSTALL);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
